// File: rtl/accel_layer_sequencer.sv
// accel_layer_sequencer: descriptor-driven layer control FSM for a PE_COUNT-wide MAC array.
// Optional build macro ACCEL_SEQ_CFGCHK_EN rejects descriptors with zero counts via sticky cfg_err.
module accel_layer_sequencer #(
    parameter int PE_COUNT = 16,
    parameter int ADDR_W   = 16,
    parameter int ADD_LAT  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [ADDR_W-1:0]   databus,
    input  logic                busrdwr,
    input  logic                dval,
    output logic [ADDR_W-1:0]   in_addr,
    output logic                w_rd,
    output logic                pe_enable,
    output logic [PE_COUNT-1:0] pe_lane_mask,
    output logic                add_done,
    output logic                neuron_done,
    output logic                out_wr,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                busy,
    output logic                layer_done,
    output logic                cfg_err
);
    localparam int LANE_W = $clog2(PE_COUNT);
    localparam int ADD_W  = $clog2(ADD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WAIT_DVAL,
        S_MAC,
        S_ADD,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0]   in_base_reg, out_base_reg, n_in_reg, n_out_reg;
    logic [ADDR_W-1:0]   in_addr_reg, out_addr_reg;
    logic [ADDR_W-1:0]   chunk_reg, neuron_reg;
    logic [2:0]          cfg_idx_reg;
    logic [LANE_W-1:0]   mac_cnt_reg;
    logic [ADD_W-1:0]    add_cnt_reg;
    logic [PE_COUNT-1:0] mask_reg;

    logic [ADDR_W-1:0]   n_in_m1, last_chunk;
    logic [LANE_W-1:0]   rem;
    logic [PE_COUNT-1:0] tail_mask;
    logic                mac_last, add_last, chunk_last, neuron_last, cfg_last, abort;

    // ceil(n/P)-1 == floor((n-1)/P); a zero count wraps to the full 2^ADDR_W range
    assign n_in_m1     = n_in_reg - ADDR_W'(1);
    assign last_chunk  = n_in_m1 >> LANE_W;
    assign rem         = n_in_reg[LANE_W-1:0];
    assign mac_last    = (mac_cnt_reg == LANE_W'(PE_COUNT - 1));
    assign add_last    = (add_cnt_reg == ADD_W'(ADD_LAT - 1));
    assign chunk_last  = (chunk_reg == last_chunk);
    assign neuron_last = (neuron_reg == n_out_reg - ADDR_W'(1));
    assign cfg_last    = (cfg_idx_reg == 3'd4);
    assign abort       = (state_reg != S_IDLE) && !enable;

    generate
        for (genvar gi = 0; gi < PE_COUNT; gi++) begin : g_tail
            assign tail_mask[gi] = (rem > LANE_W'(gi));
        end
    endgenerate

`ifdef ACCEL_SEQ_CFGCHK_EN
    logic cfg_err_reg;
    logic cfg_bad;
    // n_out arrives on the bus in the same cycle as the check
    assign cfg_bad = (n_in_reg == '0) || (databus == '0);
    assign cfg_err = cfg_err_reg;
`else
    assign cfg_err = 1'b0;
`endif

    assign in_addr      = in_addr_reg;
    assign out_addr     = out_addr_reg;
    assign pe_lane_mask = mask_reg;
    assign busy         = (state_reg != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        w_rd        = 1'b0;
        pe_enable   = 1'b0;
        add_done    = 1'b0;
        neuron_done = 1'b0;
        out_wr      = 1'b0;
        layer_done  = 1'b0;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (enable) state_next = S_CFG;
                end
                S_CFG: begin
                    if (busrdwr && cfg_last) begin
`ifdef ACCEL_SEQ_CFGCHK_EN
                        state_next = cfg_bad ? S_IDLE : S_WAIT_DVAL;
`else
                        state_next = S_WAIT_DVAL;
`endif
                    end
                end
                S_WAIT_DVAL: begin
                    if (dval) state_next = S_MAC;
                end
                S_MAC: begin
                    w_rd      = 1'b1;
                    pe_enable = 1'b1;
                    if (mac_last) state_next = S_ADD;
                end
                S_ADD: begin
                    pe_enable = 1'b1;
                    if (add_last) begin
                        add_done   = 1'b1;
                        state_next = S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (chunk_last) begin
                        neuron_done = 1'b1;
                        out_wr      = 1'b1;
                        state_next  = neuron_last ? S_DONE : S_WAIT_DVAL;
                    end else begin
                        state_next = S_WAIT_DVAL;
                    end
                end
                S_DONE: begin
                    layer_done = 1'b1;
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_base_reg  <= '0;
            out_base_reg <= '0;
            n_in_reg     <= '0;
            n_out_reg    <= '0;
            in_addr_reg  <= '0;
            out_addr_reg <= '0;
            chunk_reg    <= '0;
            neuron_reg   <= '0;
            cfg_idx_reg  <= '0;
            mac_cnt_reg  <= '0;
            add_cnt_reg  <= '0;
            mask_reg     <= '1;
`ifdef ACCEL_SEQ_CFGCHK_EN
            cfg_err_reg  <= 1'b0;
`endif
        end else if (abort) begin
            cfg_idx_reg <= '0;
            mac_cnt_reg <= '0;
            add_cnt_reg <= '0;
            chunk_reg   <= '0;
            neuron_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (enable) begin
                        cfg_idx_reg <= '0;
`ifdef ACCEL_SEQ_CFGCHK_EN
                        cfg_err_reg <= 1'b0;
`endif
                    end
                end
                S_CFG: begin
                    if (busrdwr) begin
                        // word 1 (weight base) belongs to the DRAM streamer; only its slot is consumed
                        case (cfg_idx_reg)
                            3'd0:    in_base_reg  <= databus;
                            3'd2:    out_base_reg <= databus;
                            3'd3:    n_in_reg     <= databus;
                            3'd4:    n_out_reg    <= databus;
                            default: begin end
                        endcase
                        if (cfg_last) begin
                            cfg_idx_reg  <= '0;
                            in_addr_reg  <= in_base_reg;
                            out_addr_reg <= out_base_reg;
`ifdef ACCEL_SEQ_CFGCHK_EN
                            if (cfg_bad) cfg_err_reg <= 1'b1;
`endif
                        end else begin
                            cfg_idx_reg <= cfg_idx_reg + 3'd1;
                        end
                    end
                end
                S_WAIT_DVAL: begin
                    if (dval) begin
                        mac_cnt_reg <= '0;
                        mask_reg    <= (chunk_last && rem != '0) ? tail_mask : '1;
                    end
                end
                S_MAC: begin
                    if (mac_last) begin
                        mac_cnt_reg <= '0;
                        in_addr_reg <= in_addr_reg + ADDR_W'(PE_COUNT);
                    end else begin
                        mac_cnt_reg <= mac_cnt_reg + LANE_W'(1);
                    end
                end
                S_ADD: begin
                    add_cnt_reg <= add_last ? '0 : add_cnt_reg + ADD_W'(1);
                end
                S_UPDATE: begin
                    if (!chunk_last) begin
                        chunk_reg <= chunk_reg + ADDR_W'(1);
                    end else begin
                        chunk_reg    <= '0;
                        in_addr_reg  <= in_base_reg;
                        out_addr_reg <= out_addr_reg + ADDR_W'(1);
                        neuron_reg   <= neuron_last ? '0 : neuron_reg + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    cfg_idx_reg <= '0;
                    mac_cnt_reg <= '0;
                    add_cnt_reg <= '0;
                    chunk_reg   <= '0;
                    neuron_reg  <= '0;
                end
                default: begin end
            endcase
        end
    end
endmodule

// File: tb/tb_accel_layer_sequencer.sv
// tb_accel_layer_sequencer: directed checks of descriptor load, chunking, lane masks,
// stalls, abort and reset for accel_layer_sequencer (PE_COUNT=16, ADD_LAT=5).
module tb_accel_layer_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] databus;
    logic        busrdwr;
    logic        dval;
    logic [15:0] in_addr;
    logic        w_rd;
    logic        pe_enable;
    logic [15:0] pe_lane_mask;
    logic        add_done;
    logic        neuron_done;
    logic        out_wr;
    logic [15:0] out_addr;
    logic        busy;
    logic        layer_done;
    logic        cfg_err;

    int total = 0;
    int bad   = 0;

    int w_rd_cnt = 0, out_wr_cnt = 0, add_done_cnt = 0, nd_cnt = 0, ld_cnt = 0;
    int w0, o0, a0, n0, l0;
    logic w_rd_prev = 1'b0;
    logic [15:0] addr_q[$];
    logic [15:0] mask_q[$];
    logic [15:0] base_q[$];

    accel_layer_sequencer #(.PE_COUNT(16), .ADDR_W(16), .ADD_LAT(5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .databus(databus), .busrdwr(busrdwr),
        .dval(dval), .in_addr(in_addr), .w_rd(w_rd), .pe_enable(pe_enable),
        .pe_lane_mask(pe_lane_mask), .add_done(add_done), .neuron_done(neuron_done),
        .out_wr(out_wr), .out_addr(out_addr), .busy(busy), .layer_done(layer_done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Passive recorder sampled on the falling edge
    always @(negedge clk) begin
        if (w_rd) w_rd_cnt++;
        if (w_rd && !w_rd_prev) begin
            mask_q.push_back(pe_lane_mask);
            base_q.push_back(in_addr);
        end
        w_rd_prev = w_rd;
        if (out_wr) begin
            out_wr_cnt++;
            addr_q.push_back(out_addr);
        end
        if (add_done) add_done_cnt++;
        if (neuron_done) nd_cnt++;
        if (layer_done) ld_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        w0 = w_rd_cnt; o0 = out_wr_cnt; a0 = add_done_cnt; n0 = nd_cnt; l0 = ld_cnt;
        addr_q.delete();
        mask_q.delete();
        base_q.delete();
    endtask

    task automatic start_cfg(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                             input logic [15:0] d, input logic [15:0] e);
        logic [15:0] words[5];
        words = '{a, b, c, d, e};
        enable = 1'b1;
        busrdwr = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            busrdwr = 1'b1;
            databus = words[k];
            @(posedge clk); #1;
        end
        busrdwr = 1'b0;
        databus = 16'h0;
    endtask

    task automatic wait_layer(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (layer_done) break;
        end
        chk({tag, "_layer_done"}, {31'd0, layer_done}, 32'd1);
        @(posedge clk); #1;
        enable = 1'b0;
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        $display("run %s: w_rd=%0d add_done=%0d out_wr=%0d layer_done=%0d", tag,
                 w_rd_cnt - w0, add_done_cnt - a0, out_wr_cnt - o0, ld_cnt - l0);
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; databus = 16'h0; busrdwr = 1'b0; dval = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_w_rd", {31'd0, w_rd}, 32'd0);
        chk("rst_pe_enable", {31'd0, pe_enable}, 32'd0);
        chk("rst_mask", {16'd0, pe_lane_mask}, 32'h0000FFFF);
        chk("rst_in_addr", {16'd0, in_addr}, 32'd0);
        chk("rst_out_addr", {16'd0, out_addr}, 32'd0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // 64 inputs, 3 neurons: 4 chunks each, 16 weight reads per chunk
        snap();
        dval = 1'b1;
        start_cfg(16'h0100, 16'h4000, 16'h0200, 16'd64, 16'd3);
        chk("r1_in_addr_load", {16'd0, in_addr}, 32'h0100);
        chk("r1_out_addr_load", {16'd0, out_addr}, 32'h0200);
        chk("r1_busy", {31'd0, busy}, 32'd1);
        wait_layer("r1");
        chk("r1_w_rd_cnt", w_rd_cnt - w0, 32'd192);
        chk("r1_add_done_cnt", add_done_cnt - a0, 32'd12);
        chk("r1_neuron_done_cnt", nd_cnt - n0, 32'd3);
        chk("r1_out_wr_cnt", out_wr_cnt - o0, 32'd3);
        chk("r1_layer_done_cnt", ld_cnt - l0, 32'd1);
        chk("r1_addr0", {16'd0, addr_q[0]}, 32'h0200);
        chk("r1_addr1", {16'd0, addr_q[1]}, 32'h0201);
        chk("r1_addr2", {16'd0, addr_q[2]}, 32'h0202);
        chk("r1_chunk1_base", {16'd0, base_q[1]}, 32'h0110);
        chk("r1_chunk4_base", {16'd0, base_q[4]}, 32'h0100);

        // 20 inputs: full chunk then 4-lane tail
        snap();
        start_cfg(16'h0100, 16'h0000, 16'h0300, 16'd20, 16'd1);
        wait_layer("r2");
        chk("r2_chunks", mask_q.size(), 32'd2);
        chk("r2_mask0", {16'd0, mask_q[0]}, 32'h0000FFFF);
        chk("r2_mask1", {16'd0, mask_q[1]}, 32'h0000000F);
        chk("r2_base0", {16'd0, base_q[0]}, 32'h0100);
        chk("r2_base1", {16'd0, base_q[1]}, 32'h0110);
        chk("r2_w_rd_cnt", w_rd_cnt - w0, 32'd32);
        chk("r2_out_addr", {16'd0, addr_q[0]}, 32'h0300);

        // Stall in WAIT_DVAL, then abort on the 5th MAC cycle
        snap();
        dval = 1'b0;
        start_cfg(16'h0100, 16'h0000, 16'h0200, 16'd64, 16'd3);
        repeat (50) @(posedge clk);
        #1;
        chk("r3_stall_w_rd", w_rd_cnt - w0, 32'd0);
        chk("r3_stall_busy", {31'd0, busy}, 32'd1);
        chk("r3_stall_in_addr", {16'd0, in_addr}, 32'h0100);
        dval = 1'b1;
        @(posedge clk); #1;
        dval = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        enable = 1'b0;
        #1;
        chk("r3_abort_w_rd", {31'd0, w_rd}, 32'd0);
        @(posedge clk); #1;
        chk("r3_abort_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("r3_abort_w_rd_cnt", w_rd_cnt - w0, 32'd4);
        chk("r3_abort_add_done", add_done_cnt - a0, 32'd0);
        chk("r3_abort_out_wr", out_wr_cnt - o0, 32'd0);
        chk("r3_abort_layer_done", ld_cnt - l0, 32'd0);
        $display("run r3: stalled 50 cycles, aborted after %0d weight reads", w_rd_cnt - w0);

        // Reset while draining the adder tree, then a fresh run
        dval = 1'b1;
        start_cfg(16'h0500, 16'h0000, 16'h0400, 16'd16, 16'd2);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pe_enable && !w_rd) break;
        end
        chk("r4_reached_add", {31'd0, pe_enable && !w_rd}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("r4_rst_busy", {31'd0, busy}, 32'd0);
        chk("r4_rst_pe_enable", {31'd0, pe_enable}, 32'd0);
        chk("r4_rst_add_done", {31'd0, add_done}, 32'd0);
        chk("r4_rst_in_addr", {16'd0, in_addr}, 32'd0);
        chk("r4_rst_out_addr", {16'd0, out_addr}, 32'd0);
        chk("r4_rst_mask", {16'd0, pe_lane_mask}, 32'h0000FFFF);
        rst = 1'b1;
        snap();
        start_cfg(16'h0500, 16'h0000, 16'h0400, 16'd16, 16'd2);
        wait_layer("r4");
        chk("r4_out_wr_cnt", out_wr_cnt - o0, 32'd2);
        chk("r4_addr0", {16'd0, addr_q[0]}, 32'h0400);
        chk("r4_addr1", {16'd0, addr_q[1]}, 32'h0401);
        chk("r4_w_rd_cnt", w_rd_cnt - w0, 32'd32);

`ifdef ACCEL_SEQ_CFGCHK_EN
        // Zero neuron count is rejected; a valid descriptor afterwards clears the flag
        snap();
        start_cfg(16'h0100, 16'h0000, 16'h0200, 16'd16, 16'd0);
        enable = 1'b0;
        chk("r5_cfg_err_set", {31'd0, cfg_err}, 32'd1);
        chk("r5_idle", {31'd0, busy}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("r5_cfg_err_sticky", {31'd0, cfg_err}, 32'd1);
        chk("r5_no_w_rd", w_rd_cnt - w0, 32'd0);
        start_cfg(16'h0100, 16'h0000, 16'h0200, 16'd16, 16'd1);
        chk("r5_cfg_err_clear", {31'd0, cfg_err}, 32'd0);
        wait_layer("r5");
        chk("r5_out_wr_cnt", out_wr_cnt - o0, 32'd1);
`else
        chk("cfg_err_tied_low", {31'd0, cfg_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
